reg_file_arbiter: RTL

REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

---
 rtl/reg_file_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/reg_file_arbiter.sv
// rtl/reg_file_arbiter.sv - two-requester register file write arbiter with clear sweep
module reg_file_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] Data0,
    input  logic [DATA_W-1:0] Data1,
    input  logic              Clr,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              Write_Reg,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              last, last_nxt;
    logic              gnt0_nxt, gnt1_nxt, wr_nxt, busy_nxt, done_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              win1;

    // Requester 1 wins when alone, or when both ask and requester 0 was served last.
    assign win1 = Req1 && (!Req0 || !last);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        wr_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        addr_nxt  = W_Addr;
        data_nxt  = W_Data;
        case (state)
            IDLE: begin
                if (Clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                    wr_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                    addr_nxt  = '0;
                    data_nxt  = '0;
                end else if (Req0 || Req1) begin
                    state_nxt = WRITE;
                    wr_nxt    = 1'b1;
                    last_nxt  = win1;
                    gnt0_nxt  = !win1;
                    gnt1_nxt  = win1;
                    addr_nxt  = win1 ? Addr1 : Addr0;
                    data_nxt  = win1 ? Data1 : Data0;
                end
            end
            WRITE: begin
                state_nxt = IDLE;
            end
            CLEAR: begin
                // The Done cycle is spent in IDLE, so a pending Req is granted right after it.
                if (cnt == LAST_ADDR) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt  = cnt + ADDR_ONE;
                    wr_nxt   = 1'b1;
                    busy_nxt = 1'b1;
                    addr_nxt = cnt + ADDR_ONE;
                    data_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            Gnt0      <= 1'b0;
            Gnt1      <= 1'b0;
            Write_Reg <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            W_Addr    <= '0;
            W_Data    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last      <= last_nxt;
            Gnt0      <= gnt0_nxt;
            Gnt1      <= gnt1_nxt;
            Write_Reg <= wr_nxt;
            Busy      <= busy_nxt;
            Done      <= done_nxt;
            W_Addr    <= addr_nxt;
            W_Data    <= data_nxt;
        end
    end

endmodule
